fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction memory: owns the program counter, drives the memory's word address and read enable, and absorbs the memory's one-cycle read latency. Fetched words go into a 2-entry buffer and are presented to decode with a valid/ready handshake. Supports redirect (branch/jump) with flush, and halt, at full one-instruction-per-cycle throughput.

---
 rtl/fetch_unit.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC/imem issue with 2-entry decode buffer, redirect and halt; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_instr,
  input  logic        imem_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2;
  logic [1:0] state, count, cnt_p;
  logic inflight, pop, push;
  logic [31:0] pc, req_pc;
  logic [63:0] buf_q [2];
  assign imem_addr = pc;
  assign dec_valid = count != 2'd0;
  assign {dec_instr, dec_pc} = buf_q[0];
  assign pop = dec_valid & dec_ready;
  assign push = inflight & imem_ready & !redirect;
  assign cnt_p = count - {1'b0, pop};
  assign imem_rd_en = (state == RUN) & !halt & !redirect &
                      ({1'b0, count} + {2'b0, inflight} - {2'b0, pop} <= 3'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 2'd0;
      inflight <= 1'b0;
      pc <= RESET_PC;
      req_pc <= 32'd0;
      buf_q[0] <= 64'd0;
      buf_q[1] <= 64'd0;
    end else begin
      inflight <= imem_rd_en;
      if (imem_rd_en) begin
        pc <= pc + PC_INC;
        req_pc <= pc;
      end
      if (redirect) begin
        pc <= redirect_pc;
        state <= RUN;
        count <= 2'd0;
      end else begin
        state <= (state == IDLE) ? RUN : (state == RUN && halt) ? HALTED : state;
        count <= cnt_p + {1'b0, push};
        if (pop) buf_q[0] <= buf_q[1];
        if (push) buf_q[cnt_p[0]] <= {imem_instr, req_pc};
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (state == RUN && dec_ready && !dec_valid) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif
endmodule
